// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI NOR flash read responder.
package spi_flash_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int unsigned NB_XFER_BITS = 64;

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StCmd  = 4'b0010,
    StData = 4'b0100,
    StDone = 4'b1000
  } state_e;

endpackage

// File: rtl/spi_flash_responder_if.sv
// Memory-bus read port between the core (master) and the flash responder (slave).
interface spi_flash_responder_if #(
  parameter int unsigned ADDR_WIDTH = 24
);
  logic                  sel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rstrb;
  logic [31:0]           mem_rdata;
  logic                  mem_rbusy;
  logic                  mem_wbusy;

  modport master (
    output sel, mem_addr, mem_rstrb,
    input  mem_rdata, mem_rbusy, mem_wbusy
  );

  modport slave (
    input  sel, mem_addr, mem_rstrb,
    output mem_rdata, mem_rbusy, mem_wbusy
  );
endinterface

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: half-period counter with single-cycle pulses marking the clk
// cycle on which SCK is about to rise or fall.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic sck_o,
  output logic rise_pulse_o,
  output logic fall_pulse_o
);
  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sck_q, sck_d;
  logic            tc;

  assign tc = run_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = '0;
    sck_d = 1'b0;
    if (run_i) begin
      cnt_d = tc ? '0 : cnt_q + CntW'(1);
      sck_d = tc ? ~sck_q : sck_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o        = sck_q;
  assign rise_pulse_o = tc & ~sck_q;
  assign fall_pulse_o = tc & sck_q;
endmodule

// File: rtl/spi_flash_responder.sv
// Serves 32-bit bus reads from an SPI NOR flash with the READ (0x03) command;
// the first flash byte lands in rdata[7:0].
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CS_HIGH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_flash_responder_if.slave  bus,
  output logic                  spi_cs_n,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  localparam int unsigned CsW = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;

  state_e                state_q, state_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [CsW-1:0]        cs_cnt_q, cs_cnt_d;
  logic [31:0]           shift_out_q, shift_out_d;
  logic [31:0]           shift_in_q, shift_in_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  busy_q;
  logic                  run, rise, fall, start;
  logic                  cmd_last, data_last, cs_last;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  unused_addr;

  assign addr        = bus.mem_addr;
  assign unused_addr = ^addr;  // only [23:2] reach the flash
  assign start       = bus.mem_rstrb & bus.sel;
  assign cmd_last    = fall && (bit_cnt_q == 6'(NB_XFER_BITS / 2 - 1));
  assign data_last   = fall && (bit_cnt_q == 6'(NB_XFER_BITS - 1));
  assign cs_last     = (cs_cnt_q == CsW'(CS_HIGH - 1));

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk          (clk),
    .reset        (reset),
    .run_i        (run),
    .sck_o        (spi_sck),
    .rise_pulse_o (rise),
    .fall_pulse_o (fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      cs_cnt_q    <= '0;
      shift_out_q <= '0;
      shift_in_q  <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cs_cnt_q    <= cs_cnt_d;
      shift_out_q <= shift_out_d;
      shift_in_q  <= shift_in_d;
      rdata_q     <= rdata_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start)     state_d = StCmd;
      StCmd:   if (cmd_last)  state_d = StData;
      StData:  if (data_last) state_d = StDone;
      StDone:  if (cs_last)   state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_out_d = shift_out_q;
    shift_in_d  = shift_in_q;
    rdata_d     = rdata_q;
    bit_cnt_d   = bit_cnt_q;
    cs_cnt_d    = '0;
    if (state_q == StIdle && start) shift_out_d = {SPI_CMD_READ, addr[23:2], 2'b00};
    if (state_q == StCmd && fall)   shift_out_d = {shift_out_q[30:0], 1'b0};
    if (state_q == StData && rise)  shift_in_d  = {shift_in_q[30:0], spi_miso};
    // Counts all 64 SCK periods; wraps to 0 on the last falling edge.
    if (fall) bit_cnt_d = bit_cnt_q + 6'd1;
    if (data_last) rdata_d = {shift_in_q[7:0], shift_in_q[15:8],
                              shift_in_q[23:16], shift_in_q[31:24]};
    if (state_q == StDone && !cs_last) cs_cnt_d = cs_cnt_q + CsW'(1);
  end

  always_comb begin
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    run      = 1'b0;
    unique case (state_q)
      StCmd: begin
        spi_cs_n = 1'b0;
        spi_mosi = shift_out_q[31];
        run      = 1'b1;
      end
      StData: begin
        spi_cs_n = 1'b0;
        run      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_rbusy = busy_q;
  assign bus.mem_wbusy = 1'b0;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed and randomized reads against a behavioural SPI flash model; two DUTs cover
// CLK_DIV=2 (24-bit address) and CLK_DIV=1 (32-bit address).
module tb_spi_flash_responder;
  localparam int TIMEOUT = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_flash_responder_if #(.ADDR_WIDTH(24)) ifa ();
  spi_flash_responder_if #(.ADDR_WIDTH(32)) ifb ();

  logic cs_a, sck_a, mosi_a, cs_b, sck_b, mosi_b;
  logic miso = 1'b0;
  bit   use_b = 1'b0;

  spi_flash_responder #(.ADDR_WIDTH(24), .CLK_DIV(2), .CS_HIGH(2)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifa),
    .spi_cs_n (cs_a),
    .spi_sck  (sck_a),
    .spi_mosi (mosi_a),
    .spi_miso (miso)
  );

  spi_flash_responder #(.ADDR_WIDTH(32), .CLK_DIV(1), .CS_HIGH(2)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifb),
    .spi_cs_n (cs_b),
    .spi_sck  (sck_b),
    .spi_mosi (mosi_b),
    .spi_miso (miso)
  );

  wire        f_cs_n    = use_b ? cs_b : cs_a;
  wire        f_sck     = use_b ? sck_b : sck_a;
  wire        f_mosi    = use_b ? mosi_b : mosi_a;
  wire        cur_busy  = use_b ? ifb.mem_rbusy : ifa.mem_rbusy;
  wire [31:0] cur_rdata = use_b ? ifb.mem_rdata : ifa.mem_rdata;

  // Flash contents: spec-given bytes at 0x10..0x13, a fixed scramble elsewhere.
  function automatic logic [7:0] fb(input logic [23:0] a);
    case (a)
      24'h000010: return 8'h13;
      24'h000011: return 8'h37;
      24'h000012: return 8'hBE;
      24'h000013: return 8'hEF;
      default:    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    logic [23:0] a;
    a = {addr[23:2], 2'b00};
    return {fb(a + 24'd3), fb(a + 24'd2), fb(a + 24'd1), fb(a)};
  endfunction

  // Flash model: samples MOSI on SCK rise, shifts data out on SCK fall.
  int          rise_cnt = 0;
  int          cs_epoch = 0;
  int          seen_epoch = 0;
  int          fbits = 0;
  logic [31:0] fcmd = '0;
  logic [31:0] last_cmd = '0;

  always @(negedge f_cs_n) cs_epoch++;

  always @(posedge f_sck) begin
    rise_cnt++;
    if (!f_cs_n) begin
      if (cs_epoch != seen_epoch) begin
        fbits = 0;
        seen_epoch = cs_epoch;
      end
      if (fbits < 32) fcmd = {fcmd[30:0], f_mosi};
      fbits++;
      if (fbits == 32) last_cmd = fcmd;
    end
  end

  always @(negedge f_sck) begin
    logic [23:0] ba;
    logic [7:0]  bv;
    int          k;
    if (!f_cs_n && fbits >= 32 && fbits < 64) begin
      k    = fbits - 32;
      ba   = fcmd[23:0] + 24'(k / 8);
      bv   = fb(ba);
      miso = bv[7 - (k % 8)];
    end
  end

  // Passive monitors sampled mid-cycle.
  int          wb_bad = 0;
  int          hi_run = 0;
  int          last_gap = 0;
  int          hold_bad = 0;
  bit          hold_en = 1'b0;
  logic [31:0] hold_val = '0;

  always @(negedge clk) begin
    if (ifa.mem_wbusy !== 1'b0 || ifb.mem_wbusy !== 1'b0) wb_bad++;
    if (f_cs_n) hi_run++;
    else begin
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
    end
    if (hold_en && !f_cs_n && cur_rdata !== hold_val) hold_bad++;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic stb, input logic s, input logic [31:0] a);
    if (use_b) begin
      ifb.mem_rstrb = stb;
      ifb.sel       = s;
      ifb.mem_addr  = a;
    end else begin
      ifa.mem_rstrb = stb;
      ifa.sel       = s;
      ifa.mem_addr  = a[23:0];
    end
  endtask

  // Called at a negedge; strobes, then counts busy cycles until busy drops.
  task automatic do_read(input logic [31:0] addr, input logic sel_v,
                         output logic [31:0] word, output int len);
    drive(1'b1, sel_v, addr);
    @(negedge clk);
    drive(1'b0, 1'b0, addr);
    len = 0;
    while (cur_busy && len < TIMEOUT) begin
      len++;
      @(negedge clk);
    end
    word = cur_rdata;
  endtask

  initial begin
    logic [31:0] w, w1, a;
    int          len, base;

    ifa.sel = 1'b0; ifa.mem_addr = '0; ifa.mem_rstrb = 1'b0;
    ifb.sel = 1'b0; ifb.mem_addr = '0; ifb.mem_rstrb = 1'b0;

    #3;
    check("rst_cs_n", 32'(cs_a), 32'd1);
    check("rst_sck", 32'(sck_a), 32'd0);
    check("rst_mosi", 32'(mosi_a), 32'd0);
    check("rst_rbusy", 32'(ifa.mem_rbusy), 32'd0);
    check("rst_rdata", ifa.mem_rdata, 32'd0);
    check("rst_cs_n_b", 32'(cs_b), 32'd1);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = rise_cnt;
    repeat (100) @(negedge clk);
    check("idle_no_sck", 32'(rise_cnt - base), 32'd0);
    check("idle_cs_n", 32'(cs_a), 32'd1);
    check("idle_rbusy", 32'(ifa.mem_rbusy), 32'd0);

    do_read(32'h10, 1'b1, w, len);
    check("rd10_cmd", last_cmd, 32'h03000010);
    check("rd10_busy_len", 32'(len), 32'd258);
    check("rd10_rdata", w, 32'hEFBE3713);

    base = rise_cnt;
    do_read(32'h20, 1'b0, w, len);
    repeat (20) @(negedge clk);
    check("nosel_busy_len", 32'(len), 32'd0);
    check("nosel_no_sck", 32'(rise_cnt - base), 32'd0);
    check("nosel_rdata", ifa.mem_rdata, 32'hEFBE3713);

    do_read(32'h0, 1'b1, w1, len);
    check("b2b_first", w1, exp_word(32'h0));
    hold_val = w1;
    hold_en  = 1'b1;
    do_read(32'h4, 1'b1, w, len);
    hold_en  = 1'b0;
    check("b2b_cs_gap", 32'(last_gap), 32'd3);
    check("b2b_second", w, exp_word(32'h4));
    check("b2b_busy_len", 32'(len), 32'd258);
    check("b2b_hold", 32'(hold_bad), 32'd0);

    for (int i = 0; i < 4; i++) begin
      a = {8'h00, 24'($urandom)};
      do_read(a, 1'b1, w, len);
      check("rand_cmd", last_cmd, {8'h03, a[23:2], 2'b00});
      check("rand_rdata", w, exp_word(a));
    end

    base = rise_cnt;
    drive(1'b1, 1'b1, 32'h10);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h10);
    for (int i = 0; i < TIMEOUT && (rise_cnt - base) < 40; i++) @(negedge clk);
    check("abort_reached_40", 32'(rise_cnt - base), 32'd40);
    reset = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_a), 32'd1);
    check("abort_rbusy", 32'(ifa.mem_rbusy), 32'd0);
    check("abort_rdata", ifa.mem_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_read(32'h10, 1'b1, w, len);
    check("post_abort_rdata", w, 32'hEFBE3713);

    use_b = 1'b1;
    repeat (2) @(negedge clk);
    do_read(32'hC3FF_FFFF, 1'b1, w, len);
    check("div1_cmd", last_cmd, 32'h03FFFFFC);
    check("div1_busy_len", 32'(len), 32'd130);
    check("div1_rdata", w, exp_word(32'hFFFFFC));

    check("wbusy_low", 32'(wb_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
